cpu_phase_sequencer: RTL and testbench

- Multi-cycle control FSM driving the processor datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates the execute-capture strobe (toggle), the register-file write enable, and the instruction/data memory request handshakes.
- Owns the program counter and applies PCSel/ALU-result redirects; PC stepping moves out of the testbench into RTL.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_phase_sequencer_if.sv | 26 ++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/cpu_phase_sequencer.sv | 153 +++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding and constants for the phase sequencer
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// rtl/cpu_phase_sequencer_if.sv - instruction/data memory request handshakes
interface cpu_phase_sequencer_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - shared memory-acknowledge wait counter with expiry
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count;

    // Count un-acknowledged wait cycles; every state entry restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expire on the wait cycle that would bring the count up to MAX.
    always_comb begin
        expire = enable && (count == CW'(MAX - 1));
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM; CPU_PHASE_INSTRET_EN adds instret
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int                  MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                halt_req,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                wen_in,
    input  logic                pc_sel,
    input  logic [PC_WIDTH-1:0] alu_result,
    cpu_phase_sequencer_if.master bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                toggle,
    output logic                reg_write,
    output logic [2:0]          state,
`ifdef CPU_PHASE_INSTRET_EN
    output logic [31:0]         instret,
`endif
    output logic                err
);

    state_t state_q;
    state_t state_d;

    logic                load_q;
    logic                store_q;
    logic                wen_q;
    logic                sel_q;
    logic [PC_WIDTH-1:0] alu_q;

    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expire;
    logic                misaligned;
    logic [PC_WIDTH-1:0] pc_next;

    assign misaligned = sel_q && (alu_q[1:0] != 2'b00);
    assign pc_next    = sel_q ? {alu_q[PC_WIDTH-1:2], 2'b00}
                              : pc + PC_WIDTH'(INSTR_BYTES);

    mem_wait_timer #(
        .MAX(MEM_WAIT_MAX)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and wait-timer control.
    always_comb begin
        state_d      = state_q;
        timer_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                timer_enable = !bus.imem_ack;
                if (bus.imem_ack)      state_d = S_DECODE;
                else if (timer_expire) state_d = S_ERR;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                timer_enable = !bus.dmem_ack;
                if (bus.dmem_ack)      state_d = S_WB;
                else if (timer_expire) state_d = S_ERR;
            end
            S_WB: begin
                if (misaligned)              state_d = S_ERR;
                else if (halt_req || !run)   state_d = S_HALT;
                else                         state_d = S_FETCH;
            end
            S_HALT: begin
                if (!run && !halt_req) state_d = S_IDLE;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
        timer_clear = (state_d != state_q);
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    always_comb begin
        bus.imem_req = (state_q == S_FETCH);
        bus.dmem_req = (state_q == S_MEM) && (load_q || store_q);
        bus.dmem_we  = (state_q == S_MEM) && store_q;
        toggle       = (state_q == S_EXEC);
        reg_write    = (state_q == S_WB) && wen_q && !store_q;
        err          = (state_q == S_ERR);
        state        = state_q;
    end

    // Capture the control-unit decision during EXEC; a load+store is a store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q  <= 1'b0;
            store_q <= 1'b0;
            wen_q   <= 1'b0;
            sel_q   <= 1'b0;
            alu_q   <= '0;
        end else if (state_q == S_EXEC) begin
            load_q  <= is_load && !is_store;
            store_q <= is_store;
            wen_q   <= wen_in;
            sel_q   <= pc_sel;
            alu_q   <= alu_result;
        end
    end

    // Program counter: restart value in IDLE, step or redirect on a clean WB exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (state_d == S_IDLE) begin
            pc <= RESET_PC;
        end else if ((state_q == S_WB) && !misaligned) begin
            pc <= pc_next;
        end
    end

`ifdef CPU_PHASE_INSTRET_EN
    // Retired-instruction counter; a WB that faults does not retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= 32'd0;
        end else if ((state_q == S_WB) && !misaligned) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - directed self-checking bench for cpu_phase_sequencer
module tb_cpu_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic        is_load;
    logic        is_store;
    logic        wen_in;
    logic        pc_sel;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        toggle;
    logic        reg_write;
    logic [2:0]  state;
    logic        err;
`ifdef CPU_PHASE_INSTRET_EN
    logic [31:0] instret;
`endif

    int errors = 0;
    int checks = 0;

    cpu_phase_sequencer_if bus ();

    cpu_phase_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
        .is_load    (is_load),
        .is_store   (is_store),
        .wen_in     (wen_in),
        .pc_sel     (pc_sel),
        .alu_result (alu_result),
        .bus        (bus.master),
        .pc         (pc),
        .toggle     (toggle),
        .reg_write  (reg_write),
        .state      (state),
`ifdef CPU_PHASE_INSTRET_EN
        .instret    (instret),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int we_cnt;

        reset = 1'b0; run = 1'b0; halt_req = 1'b0;
        is_load = 1'b0; is_store = 1'b0; wen_in = 1'b0; pc_sel = 1'b0;
        alu_result = 32'h0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        repeat (2) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_strobes", {28'd0, bus.imem_req, bus.dmem_req, toggle, reg_write}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // ALU instruction with immediate fetch ack: 0,1,2,3,5,1
        reset = 1'b1; run = 1'b1; bus.imem_ack = 1'b1; wen_in = 1'b1;
        tick();
        check("alu_fetch", {29'd0, state}, 32'd1);
        check("alu_imem_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        check("alu_decode", {29'd0, state}, 32'd2);
        tick();
        check("alu_exec", {29'd0, state}, 32'd3);
        check("alu_toggle", {31'd0, toggle}, 32'd1);
        tick();
        check("alu_wb", {29'd0, state}, 32'd5);
        check("alu_reg_write", {31'd0, reg_write}, 32'd1);
        check("alu_toggle_off", {31'd0, toggle}, 32'd0);
        tick();
        check("alu_refetch", {29'd0, state}, 32'd1);
        check("alu_pc", pc, 32'h4);

        // Store with dmem_ack arriving on the fourth MEM cycle
        is_store = 1'b1;
        tick(); tick();
        tick();
        cnt = 0; we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 3'd4) break;
            cnt++;
            if (bus.dmem_req && bus.dmem_we) we_cnt++;
            if (cnt == 4) bus.dmem_ack = 1'b1;
            tick();
        end
        check("st_mem_cycles", cnt, 32'd4);
        check("st_req_we_cycles", we_cnt, 32'd4);
        check("st_wb", {29'd0, state}, 32'd5);
        check("st_no_reg_write", {31'd0, reg_write}, 32'd0);
        bus.dmem_ack = 1'b0; is_store = 1'b0;
        tick();
        check("st_pc", pc, 32'h8);

        // Aligned branch, then misaligned branch
        pc_sel = 1'b1; alu_result = 32'h40; wen_in = 1'b0;
        tick(); tick(); tick();
        check("br_wb_no_write", {31'd0, reg_write}, 32'd0);
        tick();
        check("br_pc", pc, 32'h40);
        alu_result = 32'h42; wen_in = 1'b1;
        tick(); tick(); tick();
        check("mis_wb_write", {31'd0, reg_write}, 32'd1);
        tick();
        check("mis_state", {29'd0, state}, 32'd7);
        check("mis_err", {31'd0, err}, 32'd1);
        check("mis_pc", pc, 32'h40);
        repeat (3) tick();
        check("mis_sticky", {29'd0, state, err}, 32'd15);
        pc_sel = 1'b0; alu_result = 32'h0;

        // Async reset clears immediately, then fetch timeout
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", {29'd0, state}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        bus.imem_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (state != 3'd1) break;
            cnt++;
            tick();
        end
        check("to_fetch_cycles", cnt, 32'd15);
        check("to_state", {29'd0, state}, 32'd7);
        repeat (4) tick();
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Ack on the final allowed FETCH cycle wins over the timeout
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        repeat (14) tick();
        check("ackwin_fetch", {29'd0, state}, 32'd1);
        bus.imem_ack = 1'b1; is_load = 1'b1; wen_in = 1'b1;
        tick();
        check("ackwin_decode", {29'd0, state}, 32'd2);

        // Load with halt requested during MEM
        tick();
        tick();
        check("ld_mem", {29'd0, state}, 32'd4);
        check("ld_req_we", {30'd0, bus.dmem_req, bus.dmem_we}, 32'd2);
        halt_req = 1'b1;
        tick();
        check("ld_mem_hold", {29'd0, state}, 32'd4);
        bus.dmem_ack = 1'b1;
        tick();
        check("ld_wb", {29'd0, state}, 32'd5);
        check("ld_reg_write", {31'd0, reg_write}, 32'd1);
        bus.dmem_ack = 1'b0; is_load = 1'b0;
        tick();
        check("halt_state", {29'd0, state}, 32'd6);
        check("halt_pc", pc, 32'h4);
        check("halt_strobes", {28'd0, bus.imem_req, bus.dmem_req, toggle, reg_write}, 32'd0);
        run = 1'b0;
        tick();
        check("halt_hold", {29'd0, state}, 32'd6);
        halt_req = 1'b0;
        tick();
        check("idle_state", {29'd0, state}, 32'd0);
        check("idle_pc", pc, 32'h0);

        // Ten back-to-back ALU instructions, then reset during EXEC
        run = 1'b1;
        tick();
        repeat (10) begin
            repeat (4) tick();
        end
        check("run10_state", {29'd0, state}, 32'd1);
        check("run10_pc", pc, 32'h28);
`ifdef CPU_PHASE_INSTRET_EN
        check("instret_10", instret, 32'd10);
`endif
        tick(); tick();
        check("pre_rst_exec", {31'd0, toggle}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("exec_rst_state", {29'd0, state}, 32'd0);
        check("exec_rst_toggle", {31'd0, toggle}, 32'd0);
        check("exec_rst_pc", pc, 32'h0);
`ifdef CPU_PHASE_INSTRET_EN
        check("instret_rst", instret, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
